// File: rtl/mp_window_reorder_pkg.sv
// Shared types and helpers for the 2x2 window reorder block.
// Holds the FSM state encoding, the pixel width and the row-length clamp.
package mp_window_reorder_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        FILL,
        ACC0,
        ACC1,
        EM1,
        EM2,
        EM3
    } state_t;

    // Row length actually used: forced even, at least 2, at most max_w.
    function automatic int unsigned eff_len(input int unsigned row_len,
                                            input int unsigned max_w);
        int unsigned l;
        l = row_len & ~32'd1;
        if (l < 2) l = 2;
        if (l > max_w) l = max_w;
        return l;
    endfunction

endpackage

// File: rtl/mp_line_buf.sv
// One-row pixel store: synchronous write, combinational read.
// Holds the even (top) row of the current row pair.
module mp_line_buf
    import mp_window_reorder_pkg::*;
#(
    parameter int MAX_W = 32,
    parameter int AW    = $clog2(MAX_W)
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic signed [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]            rd_addr,
    output logic signed [DATA_W-1:0] rd_data
);

    logic signed [DATA_W-1:0] mem [MAX_W];

    // NOTE: no reset on the storage array; every entry is written in FILL before it is read.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mp_window_reorder.sv
// Reorders a row-major pixel stream into 2x2 window order for maxpooling,
// or passes it through with one register of delay in bypass mode.
module mp_window_reorder
    import mp_window_reorder_pkg::*;
#(
    parameter int MAX_W = 32,
    parameter int CW    = $clog2(MAX_W + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] in,
    input  logic                     in_en,
    output logic                     in_ready,
    input  logic                     pool_en,
    input  logic [CW-1:0]            row_len,
    output logic signed [DATA_W-1:0] out,
    output logic                     out_en,
    output logic                     out_mp
);

    localparam int AW = $clog2(MAX_W);

    state_t                   state;
    logic [CW-1:0]            col;
    logic [CW-1:0]            len_q;
    logic [CW-1:0]            len_eff;
    logic                     pool_q;
    logic                     pool_eff;
    logic                     boundary;
    logic                     accept;
    logic signed [DATA_W-1:0] b0;
    logic signed [DATA_W-1:0] b1;
    logic signed [DATA_W-1:0] rd_data;
    logic [AW-1:0]            rd_addr;
    logic                     wr_en;

    // Row parity is implied by the state: FILL is the even row, ACC*/EM* the odd row.
    assign boundary = (state == FILL) && (col == '0);
    assign pool_eff = boundary ? pool_en : pool_q;
    assign len_eff  = boundary ? CW'(eff_len(32'(row_len), MAX_W)) : len_q;

    // NOTE: in_ready gets a default before any condition so no latch is inferred.
    always_comb begin
        in_ready = 1'b0;
        if (!reset) in_ready = !pool_eff || (state inside {FILL, ACC0, ACC1});
    end

    assign accept  = in_en && in_ready;
    assign wr_en   = accept && pool_eff && (state == FILL);
    assign rd_addr = (state == EM1) ? AW'(col + CW'(1)) : AW'(col);

    mp_line_buf #(
        .MAX_W (MAX_W),
        .AW    (AW)
    ) u_line_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (AW'(col)),
        .wr_data (in),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= FILL;
            col    <= '0;
            pool_q <= 1'b0;
            len_q  <= CW'(2);
            b0     <= '0;
            b1     <= '0;
            out    <= '0;
            out_en <= 1'b0;
            out_mp <= 1'b0;
        end else begin
            out_en <= 1'b0;
            out_mp <= 1'b0;
            if (boundary) begin
                pool_q <= pool_en;
                len_q  <= len_eff;
            end
            if (!pool_eff) begin
                if (accept) out <= in;
                out_en <= accept;
            end else begin
                case (state)
                    FILL: begin
                        if (accept) begin
                            if (col == len_eff - CW'(1)) begin
                                state <= ACC0;
                                col   <= '0;
                            end else begin
                                col <= col + CW'(1);
                            end
                        end
                    end
                    ACC0: begin
                        if (accept) begin
                            b0    <= in;
                            state <= ACC1;
                        end
                    end
                    ACC1: begin
                        if (accept) begin
                            b1     <= in;
                            out    <= rd_data;
                            out_en <= 1'b1;
                            out_mp <= 1'b1;
                            state  <= EM1;
                        end
                    end
                    EM1: begin
                        out    <= rd_data;
                        out_en <= 1'b1;
                        out_mp <= 1'b1;
                        state  <= EM2;
                    end
                    EM2: begin
                        out    <= b0;
                        out_en <= 1'b1;
                        out_mp <= 1'b1;
                        state  <= EM3;
                    end
                    EM3: begin
                        out    <= b1;
                        out_en <= 1'b1;
                        out_mp <= 1'b1;
                        if (col + CW'(2) == len_eff) begin
                            state <= FILL;
                            col   <= '0;
                        end else begin
                            state <= ACC0;
                            col   <= col + CW'(2);
                        end
                    end
                    default: begin
                        state <= FILL;
                        col   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mp_window_reorder.sv
// Directed and randomized bench for mp_window_reorder.
// Expected streams come from a window-order model computed over whole frames.
module tb_mp_window_reorder;

    localparam int MAX_W = 8;
    localparam int CW    = $clog2(MAX_W + 1);

    logic                clk = 1'b0;
    logic                reset;
    logic signed [7:0]   in;
    logic                in_en;
    logic                in_ready;
    logic                pool_en;
    logic [CW-1:0]       row_len;
    logic signed [7:0]   out;
    logic                out_en;
    logic                out_mp;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    byte px[$];
    byte exp_v[$];
    bit  exp_mp[$];
    byte got_v[$];
    bit  got_mp[$];
    int  got_cyc[$];
    int  acc_q[$];
    int  stall_q[$];

    mp_window_reorder #(.MAX_W(MAX_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in),
        .in_en    (in_en),
        .in_ready (in_ready),
        .pool_en  (pool_en),
        .row_len  (row_len),
        .out      (out),
        .out_en   (out_en),
        .out_mp   (out_mp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (reset === 1'b0 && out_en === 1'b1) begin
            got_v.push_back(byte'(out));
            got_mp.push_back(out_mp);
            got_cyc.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int eff_l(input int r);
        int l;
        l = r - (r % 2);
        if (l < 2) l = 2;
        if (l > MAX_W) l = MAX_W;
        return l;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one pixel and hold it until the block takes it.
    task automatic push(input byte v);
        int st;
        st    = 0;
        in    = v;
        in_en = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            st++;
            if (st > 20) break;
        end
        acc_q.push_back(cyc);
        stall_q.push_back(st);
        @(posedge clk);
        #1;
        in_en = 1'b0;
        total++;
        assert (st <= 20) else begin
            bad++;
            $error("FAIL ready_timeout observed=%0d expected<=20", st);
        end
    endtask

    // Send px[] as one frame and append the expected output stream.
    task automatic send_frame(input bit pool, input int rlen, input int gap, input bit scr);
        int l;
        acc_q.delete();
        stall_q.delete();
        pool_en = pool;
        row_len = CW'(rlen);
        if (pool) begin
            l = eff_l(rlen);
            for (int w = 0; w < l / 2; w++) begin
                exp_v.push_back(px[2*w]);
                exp_v.push_back(px[2*w+1]);
                exp_v.push_back(px[l+2*w]);
                exp_v.push_back(px[l+2*w+1]);
                repeat (4) exp_mp.push_back(1'b1);
            end
        end else begin
            foreach (px[i]) begin
                exp_v.push_back(px[i]);
                exp_mp.push_back(1'b0);
            end
        end
        foreach (px[i]) begin
            push(px[i]);
            if (scr && pool) begin
                pool_en = 1'($urandom);
                row_len = CW'($urandom);
            end
            if (gap == 1) idle(1);
            else if (gap == 2) idle($urandom_range(0, 2));
        end
    endtask

    task automatic clear_q();
        exp_v.delete();
        exp_mp.delete();
        got_v.delete();
        got_mp.delete();
        got_cyc.delete();
    endtask

    task automatic check_stream(input string tag);
        int n;
        int k;
        chk({tag, "_count"}, got_v.size(), exp_v.size());
        n = (got_v.size() < exp_v.size()) ? got_v.size() : exp_v.size();
        k = 0;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_val"}, got_v[i], exp_v[i]);
            chk({tag, "_mp"}, got_mp[i], exp_mp[i]);
            if (got_mp[i]) begin
                if (k % 4 != 0) chk({tag, "_burst_gap"}, got_cyc[i], got_cyc[i-1] + 1);
                k++;
            end
        end
        clear_q();
    endtask

    initial begin
        int ra;
        int n;
        int l;
        int mx;
        bit pl;
        int stall_after8;

        reset   = 1'b1;
        in      = '0;
        in_en   = 1'b0;
        pool_en = 1'b0;
        row_len = CW'(4);
        idle(3);
        chk("rst_out", out, 0);
        chk("rst_out_en", out_en, 0);
        chk("rst_out_mp", out_mp, 0);
        chk("rst_in_ready", in_ready, 0);
        reset = 1'b0;
        idle(1);

        // Bypass pass-through.
        px = '{8'sd5, -8'sd3, 8'sd7};
        send_frame(1'b0, 4, 0, 1'b0);
        chk("byp_ready", in_ready, 1);
        idle(4);
        for (int i = 0; i < 3; i++) begin
            chk("byp_stall", stall_q[i], 0);
            if (i < got_cyc.size()) chk("byp_latency", got_cyc[i], acc_q[i] + 1);
        end
        check_stream("bypass");

        // 4x2 frame, immediately followed by the chained maxpooling frame.
        px = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5, 8'sd6, 8'sd7, 8'sd8};
        send_frame(1'b1, 4, 0, 1'b0);
        chk("frm_stall_px5", stall_q[4], 0);
        chk("frm_stall_px6", stall_q[5], 0);
        chk("frm_stall_after6", stall_q[6], 3);
        ra = acc_q[5];
        if (got_cyc.size() > 0) chk("pool_latency", got_cyc[0], ra + 1);
        else chk("pool_latency_none", got_cyc.size(), 1);
        px = '{-8'sd128, -8'sd1, 8'sd0, 8'sd127, -8'sd5, -8'sd2, 8'sd3, 8'sd100};
        send_frame(1'b1, 4, 0, 1'b0);
        stall_after8 = stall_q[0];
        chk("frm_stall_after8", stall_after8, 3);
        idle(8);
        if (got_v.size() >= 16) begin
            mx = -1000;
            for (int i = 8; i < 12; i++) if (got_v[i] > mx) mx = got_v[i];
            chk("maxpool_w0", mx, -1);
            mx = -1000;
            for (int i = 12; i < 16; i++) if (got_v[i] > mx) mx = got_v[i];
            chk("maxpool_w1", mx, 127);
        end
        check_stream("frame4x2");

        // Sparse input on a 2x2 frame.
        px = '{8'sd10, -8'sd20, 8'sd30, -8'sd40};
        send_frame(1'b1, 2, 1, 1'b0);
        idle(8);
        check_stream("sparse");

        // Row-length clamping.
        px.delete();
        repeat (8) px.push_back(byte'($urandom));
        send_frame(1'b1, 5, 0, 1'b0);
        idle(8);
        check_stream("clamp5");
        px.delete();
        repeat (4) px.push_back(byte'($urandom));
        send_frame(1'b1, 0, 0, 1'b0);
        idle(8);
        check_stream("clamp0");
        px.delete();
        repeat (2 * MAX_W) px.push_back(byte'($urandom));
        send_frame(1'b1, MAX_W + 2, 0, 1'b0);
        idle(8);
        check_stream("clampmax");

        // Reset while emitting the third window sample.
        pool_en = 1'b1;
        row_len = CW'(2);
        push(8'sd1);
        push(8'sd2);
        push(8'sd3);
        push(8'sd4);
        idle(1);
        chk("em2_out", out, 2);
        chk("em2_out_mp", out_mp, 1);
        reset = 1'b1;
        idle(1);
        chk("midrst_out_en", out_en, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out", out, 0);
        reset = 1'b0;
        idle(1);
        clear_q();
        px = '{8'sd9, -8'sd8, 8'sd7, -8'sd6};
        send_frame(1'b1, 2, 0, 1'b0);
        idle(8);
        check_stream("after_reset");

        // Randomized frames with mid-frame mode/length scrambling and gaps.
        for (int it = 0; it < 30; it++) begin
            pl = 1'($urandom_range(0, 1));
            l  = $urandom_range(0, MAX_W + 3);
            n  = pl ? 2 * eff_l(l) : $urandom_range(1, 6);
            px.delete();
            repeat (n) px.push_back(byte'($urandom));
            send_frame(pl, l, $urandom_range(0, 2), pl);
            idle(8);
            check_stream("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
